// File: rtl/wm8731_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port target.
package wm8731_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ACK0,
    S_BYTE1,
    S_ACK1,
    S_BYTE2,
    S_ACK2,
    S_EXTRA,
    S_IGNORE
  } state_t;

  localparam int REG_LLINE  = 0;
  localparam int REG_RLINE  = 1;
  localparam int REG_LOUT   = 2;
  localparam int REG_ROUT   = 3;
  localparam int REG_APATH  = 4;
  localparam int REG_DPATH  = 5;
  localparam int REG_POWER  = 6;
  localparam int REG_DAIF   = 7;
  localparam int REG_SAMPLE = 8;
  localparam int REG_ACTIVE = 9;
  localparam int REG_RESET  = 15;

  localparam logic [7:0] ADDR_BYTE_W = 8'h34;

  // Element i holds the power-on value of register i (index 0 is the LSB slice).
  localparam logic [9:0][8:0] WM_DEFAULTS = {
    9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
    9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
  };

  function automatic logic [15:0][8:0] reg_defaults();
    logic [15:0][8:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i] = WM_DEFAULTS[i];
    return r;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and flags edges, START and STOP.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Idle bus is high on both lines; reset there so no false START/STOP appears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign o_scl_rise = scl_s & ~scl_hist_q;
  assign o_scl_fall = ~scl_s & scl_hist_q;
  assign o_start    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign o_stop     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign o_sda      = sda_s;

endmodule

// File: rtl/i2c_codec_target.sv
// WM8731 control-port I2C target: ACKs 3-byte write frames and strobes one register write per frame.
// Define I2C_TGT_REGFILE_EN to build the 16x9 shadow register file behind o_rd_data.
module i2c_codec_target
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_busy,
  output logic       o_err,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_scl     (i_scl),
    .i_sda     (i_sda),
    .o_scl_rise(scl_rise),
    .o_scl_fall(scl_fall),
    .o_start   (start),
    .o_stop    (stop),
    .o_sda     (sda_s)
  );

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte1_q, byte1_d;
  logic       oen_q, oen_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    byte1_d    = byte1_q;
    oen_d      = oen_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    // Bus conditions take priority over bit sampling.
    if (start) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      oen_d   = 1'b0;
      busy_d  = 1'b1;
    end else if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      oen_d   = 1'b0;
      busy_d  = 1'b0;
      err_d   = state_q inside {S_ADDR, S_ACK0, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2};
    end else begin
      unique case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == S_ADDR) begin
                if (rx_byte == {DEV_ADDR, 1'b0}) state_d = S_ACK0;
                else begin
                  state_d = S_IGNORE;
                  err_d   = 1'b1;
                end
              end else if (state_q == S_BYTE1) begin
                byte1_d = rx_byte;
                state_d = S_ACK1;
              end else begin
                state_d = S_ACK2;
              end
            end
          end
        end
        // First SCL fall drives the ACK, second one ends the 9th clock.
        S_ACK0, S_ACK1, S_ACK2: begin
          if (scl_fall) begin
            if (!oen_q) begin
              oen_d = 1'b1;
              if (state_q == S_ACK2) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = byte1_q[7:1];
                wr_data_d  = {byte1_q[0], shift_q};
              end
            end else begin
              oen_d   = 1'b0;
              state_d = (state_q == S_ACK0) ? S_BYTE1 :
                        (state_q == S_ACK1) ? S_BYTE2 : S_EXTRA;
            end
          end
        end
        // Extra bytes are counted through their 9th clock and left unacknowledged.
        S_EXTRA: begin
          if (scl_rise) begin
            cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
            err_d = (cnt_q == 4'd7);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      byte1_q    <= '0;
      oen_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      byte1_q    <= byte1_d;
      oen_q      <= oen_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_sda_oen  = oen_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

`ifdef I2C_TGT_REGFILE_EN
  logic [15:0][8:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_valid_q) begin
      if (wr_addr_q <= 7'(REG_ACTIVE)) regs_d[wr_addr_q[3:0]] = wr_data_q;
      else if (wr_addr_q == 7'(REG_RESET)) regs_d = reg_defaults();
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) regs_q <= reg_defaults();
    else       regs_q <= regs_d;
  end

  assign o_rd_data = regs_q[i_rd_addr];
`else
  logic unused_rd;
  assign unused_rd = ^i_rd_addr;
  assign o_rd_data = '0;
`endif

endmodule

// File: tb/tb_i2c_codec_target.sv
// Randomized I2C master driving the codec target; a scoreboard checks commit/error strobes.
module tb_i2c_codec_target;

  localparam int Q = 10;  // quarter SCL period in i_clk cycles

  typedef struct {
    bit         is_commit;
    logic [6:0] a;
    logic [8:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, scl, sda_drv, sda_bus;
  logic [3:0] rd_addr;
  logic       oen, wr_valid, busy, err;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;

  int   total = 0, bad = 0;
  ev_t  exp_q[$];
  logic [7:0] frame_q[$];
  logic [8:0] sh[16];

  always #10 clk = ~clk;
  assign sda_bus = sda_drv & ~oen;

  i2c_codec_target dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_bus),
    .o_sda_oen(oen), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_busy(busy), .o_err(err),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shadow model: WM8731 power-on values, only present when the regfile is built.
  task automatic sh_reset();
    logic [8:0] defs[10];
    defs = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
    for (int i = 0; i < 16; i++) sh[i] = '0;
`ifdef I2C_TGT_REGFILE_EN
    for (int i = 0; i < 10; i++) sh[i] = defs[i];
`endif
  endtask

  task automatic sh_commit(input logic [6:0] a, input logic [8:0] d);
`ifdef I2C_TGT_REGFILE_EN
    if (a <= 7'd9) sh[a[3:0]] = d;
    else if (a == 7'd15) sh_reset();
`endif
  endtask

  task automatic check_shadow();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk($sformatf("shadow[%0d]", i), rd_data, sh[i]);
    end
  endtask

  task automatic send_start();
    sda_drv = 1'b1; wq(Q);
    scl = 1'b1;     wq(Q);
    sda_drv = 1'b0; wq(Q);
    scl = 1'b0;     wq(Q);
  endtask

  task automatic send_stop();
    sda_drv = 1'b0; wq(Q);
    scl = 1'b1;     wq(Q);
    sda_drv = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; wq(Q);
    scl = 1'b1;  wq(2 * Q);
    scl = 1'b0;  wq(Q);
  endtask

  task automatic get_ack(output logic a);
    sda_drv = 1'b1; wq(Q);
    scl = 1'b1;     wq(Q);
    a = ~sda_bus;   wq(Q);
    scl = 1'b0;     wq(Q);
  endtask

  // Expected behaviour from the protocol rules: 0x34 opens a write, bytes 1-2 form
  // the register write, later bytes and short STOP-terminated frames are errors.
  task automatic run_frame(input bit end_stop);
    int   n;
    bit   matched;
    logic a;
    ev_t  e;
    n = frame_q.size();
    matched = (frame_q[0] == 8'h34);
    send_start();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && !matched) begin
        e = '{0, '0, '0}; exp_q.push_back(e);
      end
      if (matched && i == 2) begin
        e = '{1, frame_q[1][7:1], {frame_q[1][0], frame_q[2]}};
        exp_q.push_back(e);
        sh_commit(e.a, e.d);
      end
      if (matched && i >= 3) begin
        e = '{0, '0, '0}; exp_q.push_back(e);
      end
      for (int b = 7; b >= 0; b--) send_bit(frame_q[i][b]);
      get_ack(a);
      chk($sformatf("ack_byte%0d", i), a, (matched && i < 3) ? 1 : 0);
    end
    if (end_stop) begin
      if (matched && n < 3) begin
        e = '{0, '0, '0}; exp_q.push_back(e);
      end
      send_stop();
      wq(Q);
      chk("busy_after_stop", busy, 0);
      check_shadow();
    end
  endtask

  // Scoreboard monitor: each strobe consumes the next expected event.
  always @(negedge clk) begin
    if (!rst && (wr_valid || err)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b expected none", wr_valid, err);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_is_commit", wr_valid, e.is_commit);
        chk("event_is_err", err, e.is_commit ? 0 : 1);
        if (e.is_commit) begin
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
    end
  end

  initial begin
    logic a;
    int   n, guard;
    bit   stop_end;
    rst = 1'b1; scl = 1'b1; sda_drv = 1'b1; rd_addr = '0;
    wq(5);
    chk("rst_oen", oen, 0);
    chk("rst_valid", wr_valid, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    sh_reset();
    check_shadow();

    frame_q = '{8'h34, 8'h1E, 8'h00};         run_frame(1);
    frame_q = '{8'h34, 8'h08, 8'h15};         run_frame(1);
    frame_q = '{8'h36, 8'h0C, 8'h00};         run_frame(1);
    frame_q = '{8'h34, 8'h0C, 8'h00};         run_frame(1);
    frame_q = '{8'h34, 8'h12};                run_frame(1);
    frame_q = '{8'h34, 8'h0E, 8'h4A, 8'hFF};  run_frame(1);
    frame_q = '{8'h34, 8'h10};                run_frame(0);
    frame_q = '{8'h34, 8'h10, 8'h01};         run_frame(1);

    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 4);
      frame_q = {};
      frame_q.push_back(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h34);
      if (n > 1) frame_q.push_back({4'($urandom), 4'($urandom)});
      for (int i = 2; i < n; i++) frame_q.push_back(8'($urandom));
      stop_end = (f == 13) || ($urandom_range(0, 3) != 0);
      run_frame(stop_end);
    end

    // Reset while the target holds the address ACK.
    send_start();
    for (int b = 7; b >= 0; b--) send_bit(((8'h34 >> b) & 8'h01) != 0);
    sda_drv = 1'b1;
    guard = 0;
    while (!oen && guard < 40) begin
      @(negedge clk); guard++;
    end
    chk("ack_before_rst", oen, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_releases_sda", oen, 0);
    chk("rst_clears_busy", busy, 0);
    rst = 1'b0;
    sh_reset();
    send_stop();
    wq(Q);
    chk("busy_idle_after_rst", busy, 0);
    check_shadow();

    wq(4 * Q);
    chk("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
